// File: rtl/ex_wb_commit_pkg.sv
// ex_wb_commit_pkg: opcode map, exception codes, WB state encoding and op-class helpers.
package ex_wb_commit_pkg;
  localparam int OPW = 6;
  typedef enum logic [2:0] {IDLE, HOLD, MREQ, MRESP, DRAIN} st_t;
  localparam logic [4:0] NO_EXC = 5'h1f, ADEL = 5'd4, ADES = 5'd5, DBE = 5'd7, OV = 5'd12;
  localparam logic [3:0] BE_B = 4'b0001, BE_H = 4'b0011, BE_W = 4'b1111;
  localparam logic [OPW-1:0] OP_ADD = 6'd0, OP_ADDU = 6'd1, OP_SUB = 6'd2, OP_SUBU = 6'd3;
  localparam logic [OPW-1:0] OP_AND = 6'd4, OP_OR = 6'd5, OP_XOR = 6'd6, OP_NOR = 6'd7;
  localparam logic [OPW-1:0] OP_SLT = 6'd8, OP_SLTU = 6'd9, OP_SLL = 6'd10, OP_SRL = 6'd11;
  localparam logic [OPW-1:0] OP_SRA = 6'd12, OP_LUI = 6'd13, OP_ADDI = 6'd14;
  localparam logic [OPW-1:0] OP_MFHI = 6'd15, OP_MFLO = 6'd16, OP_MFC0 = 6'd17;
  localparam logic [OPW-1:0] OP_MTHI = 6'd18, OP_MTLO = 6'd19, OP_MTC0 = 6'd20, OP_ERET = 6'd21;
  localparam logic [OPW-1:0] OP_BEQ = 6'd22, OP_BNE = 6'd23, OP_BGEZ = 6'd24, OP_BGTZ = 6'd25;
  localparam logic [OPW-1:0] OP_BLEZ = 6'd26, OP_BLTZ = 6'd27, OP_BGEZAL = 6'd28, OP_BLTZAL = 6'd29;
  localparam logic [OPW-1:0] OP_J = 6'd30, OP_JAL = 6'd31, OP_JR = 6'd32, OP_JALR = 6'd33;
  localparam logic [OPW-1:0] OP_LB = 6'd34, OP_LBU = 6'd35, OP_LH = 6'd36, OP_LHU = 6'd37;
  localparam logic [OPW-1:0] OP_LW = 6'd38, OP_SB = 6'd39, OP_SH = 6'd40, OP_SW = 6'd41;
  function automatic logic is_load(input logic [OPW-1:0] op);
    return op inside {[OP_LB:OP_LW]};
  endfunction
  function automatic logic is_store(input logic [OPW-1:0] op);
    return op inside {[OP_SB:OP_SW]};
  endfunction
  function automatic logic is_branch(input logic [OPW-1:0] op);
    return op inside {[OP_BEQ:OP_JALR]};
  endfunction
  function automatic logic writes_rf(input logic [OPW-1:0] op);
    return op inside {[OP_ADD:OP_MFC0], OP_JAL, OP_JALR, OP_BGEZAL, OP_BLTZAL};
  endfunction
  function automatic logic is_ovf(input logic [OPW-1:0] op);
    return op inside {OP_ADD, OP_ADDI, OP_SUB};
  endfunction
  function automatic logic is_byte(input logic [OPW-1:0] op);
    return op inside {OP_LB, OP_LBU, OP_SB};
  endfunction
  function automatic logic is_half(input logic [OPW-1:0] op);
    return op inside {OP_LH, OP_LHU, OP_SH};
  endfunction
  function automatic logic misaligned(input logic [OPW-1:0] op, input logic [1:0] a);
    return is_half(op) ? a[0] : op inside {OP_LW, OP_SW} ? |a : 1'b0;
  endfunction
endpackage

// File: rtl/ex_wb_commit_align.sv
// wb_load_align: store byte enables and lane-replicated data, load lane extract with sign/zero extend.
module wb_load_align
  import ex_wb_commit_pkg::*;
(
  input  logic [OPW-1:0] op,
  input  logic [1:0]     a,
  input  logic [31:0]    rdata,
  input  logic [31:0]    wr,
  output logic [3:0]     be,
  output logic [31:0]    wdata,
  output logic [31:0]    ldata
);
  logic [7:0] b;
  logic [15:0] h;
  always_comb begin
    b = rdata[{a, 3'b000} +: 8];
    h = a[1] ? rdata[31:16] : rdata[15:0];
    be = is_byte(op) ? BE_B << a : is_half(op) ? BE_H << {a[1], 1'b0} : BE_W;
    wdata = is_byte(op) ? {4{wr[7:0]}} : is_half(op) ? {2{wr[15:0]}} : wr;
    ldata = op == OP_LB ? {{24{b[7]}}, b}
          : op == OP_LBU ? {24'd0, b}
          : op == OP_LH ? {{16{h[15]}}, h}
          : op == OP_LHU ? {16'd0, h}
          : rdata;
  end
endmodule

// File: rtl/ex_wb_commit.sv
// ex_wb_commit: WB stage -- data-memory access, load align, rf commit, mispredict redirect, precise exceptions.
// Build option WB_ADDR_EXC_EN: misaligned LH/LHU/LW and SH/SW trap (AdEL/AdES) instead of being forced aligned.
module ex_wb_commit
  import ex_wb_commit_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255,
  parameter int OP_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            ex_valid_ns,
  output logic            wb_allin,
  input  logic [4:0]      ex_dest_addr,
  input  logic [31:0]     ex_pc,
  input  logic [OP_W-1:0] ex_op,
  input  logic [31:0]     ex_out,
  input  logic [31:0]     ex_out_wr,
  input  logic            ex_fu_ov,
  input  logic [4:0]      ex_exp_code,
  input  logic            ex_branchcond,
  input  logic            ex_bp_result,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [3:0]      dmem_be,
  output logic [31:0]     dmem_addr,
  output logic [31:0]     dmem_wdata,
  input  logic            dmem_ack,
  input  logic [31:0]     dmem_rdata,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [31:0]     rf_wdata,
  output logic            redirect_valid,
  output logic [31:0]     redirect_pc,
  output logic            exc_valid,
  output logic [4:0]      exc_code,
  output logic [31:0]     exc_pc,
  output logic [31:0]     exc_badvaddr
);
  st_t state, ns;
  logic [OP_W-1:0] e_op;
  logic [4:0] e_dest, e_exc, c_exc;
  logic [31:0] e_pc, e_out, e_wr, ld_q, ld_val, wdata;
  logic [15:0] cnt;
  logic [3:0] be;
  logic e_bp, tmo, accept, to, hold_c, ok, req, unused_ok;
  assign unused_ok = ex_branchcond;
  assign wb_allin = (state == IDLE || state == HOLD || state == MREQ && 1'b0 || state == MRESP) && !flush;
  assign accept = wb_allin && ex_valid_ns;
  assign to = ACK_TIMEOUT != 0 && state == MREQ && !dmem_ack && cnt == 16'(ACK_TIMEOUT);
  assign c_exc = ex_exp_code != NO_EXC ? ex_exp_code
               : ex_fu_ov && is_ovf(ex_op) ? OV
`ifdef WB_ADDR_EXC_EN
               : misaligned(ex_op, ex_out[1:0]) ? (is_store(ex_op) ? ADES : ADEL)
`endif
               : NO_EXC;
  always_comb begin
    ns = IDLE;
    if (accept) ns = c_exc == NO_EXC && (is_load(ex_op) || is_store(ex_op)) ? MREQ : HOLD;
    else if (state == MREQ) ns = dmem_ack ? (is_load(e_op) && !flush ? MRESP : IDLE) : (flush || to ? DRAIN : MREQ);
    else if (state == DRAIN) ns = dmem_ack ? IDLE : DRAIN;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      tmo <= 1'b0;
      ld_q <= '0;
      e_op <= '0;
      e_dest <= '0;
      e_pc <= '0;
      e_out <= '0;
      e_wr <= '0;
      e_bp <= 1'b0;
      e_exc <= NO_EXC;
    end else begin
      state <= ns;
      cnt <= state == MREQ && !dmem_ack ? cnt + 16'd1 : '0;
      tmo <= ns == DRAIN && (tmo || (to && !flush));
      if (state == MREQ && dmem_ack) ld_q <= dmem_rdata;
      if (accept) begin
        e_op <= ex_op;
        e_dest <= ex_dest_addr;
        e_pc <= ex_pc;
        e_out <= ex_out;
        e_wr <= ex_out_wr;
        e_bp <= ex_bp_result;
        e_exc <= c_exc;
      end
    end
  end
  wb_load_align u_align (
    .op(e_op), .a(e_out[1:0]), .rdata(ld_q), .wr(e_wr), .be(be), .wdata(wdata), .ldata(ld_val)
  );
  // A timed-out request is dropped in DRAIN; a flushed one stays on the bus until its ack.
  always_comb begin
    hold_c = state == HOLD && !flush;
    ok = hold_c && e_exc == NO_EXC;
    req = state == MREQ || (state == DRAIN && !tmo);
    dmem_req = req;
    dmem_we = req && is_store(e_op);
    dmem_be = req ? be : '0;
    dmem_addr = req ? {e_out[31:2], 2'b00} : '0;
    dmem_wdata = req && is_store(e_op) ? wdata : '0;
    rf_we = e_dest != 5'd0 && ((ok && writes_rf(e_op)) || (state == MRESP && !flush));
    rf_waddr = rf_we ? e_dest : '0;
    rf_wdata = !rf_we ? '0 : state == MRESP ? ld_val : e_out;
    redirect_valid = ok && is_branch(e_op) && !e_bp;
    redirect_pc = redirect_valid ? e_wr : '0;
    exc_valid = (hold_c && e_exc != NO_EXC) || (to && !flush);
    exc_code = !exc_valid ? '0 : state == HOLD ? e_exc : DBE;
    exc_pc = exc_valid ? e_pc : '0;
    exc_badvaddr = exc_valid && exc_code inside {ADEL, ADES, DBE} ? e_out : '0;
  end
endmodule

// File: tb/tb_ex_wb_commit.sv
// tb_ex_wb_commit: directed vectors with hand-computed expectations for ex_wb_commit.
module tb_ex_wb_commit;
  import ex_wb_commit_pkg::*;
  logic clk = 1'b0, reset, flush, ex_valid_ns, wb_allin, ex_fu_ov, ex_branchcond, ex_bp_result;
  logic [4:0] ex_dest_addr, ex_exp_code, rf_waddr, exc_code;
  logic [31:0] ex_pc, ex_out, ex_out_wr, dmem_addr, dmem_wdata, dmem_rdata, rf_wdata, redirect_pc, exc_pc, exc_badvaddr;
  logic [5:0] ex_op;
  logic dmem_req, dmem_we, dmem_ack, rf_we, redirect_valid, exc_valid;
  logic [3:0] dmem_be;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  ex_wb_commit dut (
    .clk(clk), .reset(reset), .flush(flush), .ex_valid_ns(ex_valid_ns), .wb_allin(wb_allin),
    .ex_dest_addr(ex_dest_addr), .ex_pc(ex_pc), .ex_op(ex_op), .ex_out(ex_out), .ex_out_wr(ex_out_wr),
    .ex_fu_ov(ex_fu_ov), .ex_exp_code(ex_exp_code), .ex_branchcond(ex_branchcond), .ex_bp_result(ex_bp_result),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .exc_valid(exc_valid), .exc_code(exc_code),
    .exc_pc(exc_pc), .exc_badvaddr(exc_badvaddr)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [5:0] op, input logic [4:0] dest, input logic [31:0] pc, input logic [31:0] out,
                       input logic [31:0] wr, input logic ov, input logic [4:0] ec, input logic bp);
    ex_valid_ns = 1'b1;
    ex_op = op;
    ex_dest_addr = dest;
    ex_pc = pc;
    ex_out = out;
    ex_out_wr = wr;
    ex_fu_ov = ov;
    ex_exp_code = ec;
    ex_bp_result = bp;
  endtask
  task automatic idle();
    ex_valid_ns = 1'b0;
    ex_fu_ov = 1'b0;
    ex_exp_code = NO_EXC;
    ex_bp_result = 1'b1;
  endtask
  task automatic beat(input logic [5:0] op, input logic [4:0] dest, input logic [31:0] pc, input logic [31:0] out,
                      input logic [31:0] wr, input logic ov, input logic [4:0] ec, input logic bp);
    drive(op, dest, pc, out, wr, ov, ec, bp);
    step();
    idle();
  endtask
  logic [5:0] lop [4] = '{OP_LBU, OP_LH, OP_LHU, OP_LW};
  logic [31:0] ladr [4] = '{32'h1002, 32'h1002, 32'h1000, 32'h1004};
  logic [31:0] lrd [4] = '{32'h1280FFFF, 32'h80010000, 32'h12348001, 32'hDEADBEEF};
  logic [31:0] lexp [4] = '{32'h00000080, 32'hFFFF8001, 32'h00008001, 32'hDEADBEEF};
  logic [3:0] lbe [4] = '{4'b0100, 4'b1100, 4'b0011, 4'b1111};
  initial begin
    int k;
    reset = 1'b1;
    flush = 1'b0;
    ex_branchcond = 1'b0;
    ex_dest_addr = '0;
    ex_pc = '0;
    ex_op = '0;
    ex_out = '0;
    ex_out_wr = '0;
    dmem_ack = 1'b0;
    dmem_rdata = '0;
    idle();
    step();
    step();
    @(negedge clk);
    check("rst_allin", wb_allin, 1);
    check("rst_rfwe", rf_we, 0);
    check("rst_req", dmem_req, 0);
    check("rst_exc", exc_valid, 0);
    check("rst_redir", redirect_valid, 0);
    check("rst_wdata", rf_wdata, 0);
    reset = 1'b0;
    beat(OP_ADDU, 5, 32'h100, 32'h12345678, 0, 0, NO_EXC, 1);
    @(negedge clk);
    check("addu_we", rf_we, 1);
    check("addu_wa", rf_waddr, 5);
    check("addu_wd", rf_wdata, 32'h12345678);
    check("addu_allin", wb_allin, 1);
    step();
    @(negedge clk);
    check("addu_we_off", rf_we, 0);
    drive(OP_ADDU, 6, 32'h104, 32'hA, 0, 0, NO_EXC, 1);
    step();
    drive(OP_SUBU, 7, 32'h108, 32'hB, 0, 0, NO_EXC, 1);
    @(negedge clk);
    check("b2b_wa0", rf_waddr, 6);
    check("b2b_wd0", rf_wdata, 32'hA);
    check("b2b_allin", wb_allin, 1);
    step();
    idle();
    @(negedge clk);
    check("b2b_wa1", rf_waddr, 7);
    check("b2b_wd1", rf_wdata, 32'hB);
    beat(OP_ADDU, 0, 32'h10C, 32'h55, 0, 0, NO_EXC, 1);
    @(negedge clk);
    check("dest0_we", rf_we, 0);
    beat(OP_ADD, 8, 32'h200, 32'h80000000, 0, 1, NO_EXC, 1);
    @(negedge clk);
    check("ov_exc", exc_valid, 1);
    check("ov_code", exc_code, 12);
    check("ov_pc", exc_pc, 32'h200);
    check("ov_we", rf_we, 0);
    step();
    @(negedge clk);
    check("ov_pulse", exc_valid, 0);
    beat(OP_ADDU, 8, 32'h204, 32'h80000000, 0, 1, NO_EXC, 1);
    @(negedge clk);
    check("addu_ov_exc", exc_valid, 0);
    check("addu_ov_we", rf_we, 1);
    beat(OP_BEQ, 0, 32'h300, 0, 32'h400, 0, 5'd10, 0);
    @(negedge clk);
    check("upexc_exc", exc_valid, 1);
    check("upexc_code", exc_code, 10);
    check("upexc_redir", redirect_valid, 0);
    check("upexc_bva", exc_badvaddr, 0);
    beat(OP_BEQ, 0, 32'h304, 0, 32'h400, 0, NO_EXC, 0);
    @(negedge clk);
    check("beq_redir", redirect_valid, 1);
    check("beq_pc", redirect_pc, 32'h400);
    check("beq_we", rf_we, 0);
    step();
    @(negedge clk);
    check("beq_pulse", redirect_valid, 0);
    beat(OP_BEQ, 0, 32'h308, 0, 32'h400, 0, NO_EXC, 1);
    @(negedge clk);
    check("beq_ok_redir", redirect_valid, 0);
    beat(OP_JAL, 31, 32'h30C, 32'h310, 32'h800, 0, NO_EXC, 1);
    @(negedge clk);
    check("jal_we", rf_we, 1);
    check("jal_wd", rf_wdata, 32'h310);
    beat(OP_LB, 7, 32'h400, 32'h1003, 0, 0, NO_EXC, 1);
    @(negedge clk);
    check("lb_req", dmem_req, 1);
    check("lb_we", dmem_we, 0);
    check("lb_be", dmem_be, 4'b1000);
    check("lb_addr", dmem_addr, 32'h1000);
    check("lb_allin", wb_allin, 0);
    step();
    @(negedge clk);
    check("lb_wait", dmem_req, 1);
    step();
    dmem_ack = 1'b1;
    dmem_rdata = 32'h80FFFFFF;
    @(negedge clk);
    check("lb_ackreq", dmem_req, 1);
    check("lb_ackwe", rf_we, 0);
    step();
    dmem_ack = 1'b0;
    @(negedge clk);
    check("lb_rfwe", rf_we, 1);
    check("lb_wa", rf_waddr, 7);
    check("lb_wd", rf_wdata, 32'hFFFFFF80);
    check("lb_allin2", wb_allin, 1);
    check("lb_reqoff", dmem_req, 0);
    for (int i = 0; i < 4; i++) begin
      beat(lop[i], 9, 32'h500, ladr[i], 0, 0, NO_EXC, 1);
      @(negedge clk);
      check("ld_be", dmem_be, lbe[i]);
      dmem_ack = 1'b1;
      dmem_rdata = lrd[i];
      step();
      dmem_ack = 1'b0;
      @(negedge clk);
      check("ld_wd", rf_wdata, lexp[i]);
    end
    beat(OP_SH, 3, 32'h510, 32'h2002, 32'h0000BEEF, 0, NO_EXC, 1);
    @(negedge clk);
    check("sh_we", dmem_we, 1);
    check("sh_be", dmem_be, 4'b1100);
    check("sh_wdata", dmem_wdata, 32'hBEEFBEEF);
    check("sh_addr", dmem_addr, 32'h2000);
    check("sh_rfwe", rf_we, 0);
    dmem_ack = 1'b1;
    step();
    dmem_ack = 1'b0;
    @(negedge clk);
    check("sh_done_req", dmem_req, 0);
    check("sh_done_rfwe", rf_we, 0);
    check("sh_done_allin", wb_allin, 1);
    beat(OP_SB, 0, 32'h514, 32'h2001, 32'h000000AB, 0, NO_EXC, 1);
    @(negedge clk);
    check("sb_be", dmem_be, 4'b0010);
    check("sb_wdata", dmem_wdata, 32'hABABABAB);
    dmem_ack = 1'b1;
    step();
    dmem_ack = 1'b0;
    beat(OP_LW, 4, 32'h520, 32'h3001, 0, 0, NO_EXC, 1);
    @(negedge clk);
`ifdef WB_ADDR_EXC_EN
    check("lwmis_exc", exc_valid, 1);
    check("lwmis_code", exc_code, 4);
    check("lwmis_bva", exc_badvaddr, 32'h3001);
    check("lwmis_req", dmem_req, 0);
    beat(OP_SW, 0, 32'h524, 32'h2002, 32'h1, 0, NO_EXC, 1);
    @(negedge clk);
    check("swmis_code", exc_code, 5);
    check("swmis_req", dmem_req, 0);
`else
    check("lwmis_exc", exc_valid, 0);
    check("lwmis_req", dmem_req, 1);
    check("lwmis_addr", dmem_addr, 32'h3000);
    check("lwmis_be", dmem_be, 4'b1111);
    dmem_ack = 1'b1;
    step();
    dmem_ack = 1'b0;
`endif
    beat(OP_ADDU, 5, 32'h600, 32'h77, 0, 0, NO_EXC, 1);
    flush = 1'b1;
    @(negedge clk);
    check("fhold_we", rf_we, 0);
    check("fhold_allin", wb_allin, 0);
    step();
    flush = 1'b0;
    @(negedge clk);
    check("fhold_we2", rf_we, 0);
    drive(OP_ADDU, 5, 32'h604, 32'h88, 0, 0, NO_EXC, 1);
    flush = 1'b1;
    step();
    idle();
    flush = 1'b0;
    @(negedge clk);
    check("facc_we", rf_we, 0);
    beat(OP_LW, 9, 32'h608, 32'h4000, 0, 0, NO_EXC, 1);
    flush = 1'b1;
    @(negedge clk);
    check("fmreq_req", dmem_req, 1);
    check("fmreq_allin", wb_allin, 0);
    for (int i = 0; i < 2; i++) begin
      step();
      flush = 1'b0;
      @(negedge clk);
      check("fdrain_req", dmem_req, 1);
      check("fdrain_allin", wb_allin, 0);
    end
    step();
    dmem_ack = 1'b1;
    dmem_rdata = 32'h11111111;
    @(negedge clk);
    check("fack_req", dmem_req, 1);
    check("fack_allin", wb_allin, 0);
    step();
    dmem_ack = 1'b0;
    @(negedge clk);
    check("fpost_allin", wb_allin, 1);
    check("fpost_req", dmem_req, 0);
    check("fpost_we", rf_we, 0);
    step();
    @(negedge clk);
    check("fpost_we2", rf_we, 0);
    beat(OP_LW, 10, 32'h700, 32'h5000, 0, 0, NO_EXC, 1);
    @(negedge clk);
    k = 0;
    while (!exc_valid && k < 400) begin
      step();
      @(negedge clk);
      k++;
    end
    check("to_cycles", k, 255);
    check("to_code", exc_code, 7);
    check("to_pc", exc_pc, 32'h700);
    check("to_bva", exc_badvaddr, 32'h5000);
    step();
    @(negedge clk);
    check("to_drop", dmem_req, 0);
    check("to_allin", wb_allin, 0);
    check("to_pulse", exc_valid, 0);
    dmem_ack = 1'b1;
    step();
    dmem_ack = 1'b0;
    @(negedge clk);
    check("late_allin", wb_allin, 1);
    check("late_we", rf_we, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
